// File: rtl/hp_vpu_pkg.sv
// Shared VPU types and widths used by the LUT arbiter and other shared-resource blocks.
// Pure declarations: no logic, no latency, no flow control.
package hp_vpu_pkg;

  localparam int LUT_IDX_W     = 8;
  localparam int LUT_FUNC_W    = 2;
  localparam int LUT_DATA_W    = 16;
  localparam int LUT_ID_W      = 3;  // holds a requester id for up to 8 requesters
  localparam int LUT_TAG_MAX_W = 8;  // widest requester tag the pipeline can carry

  typedef enum logic [LUT_FUNC_W-1:0] {
    LUT_FN_EXP     = 2'd0,
    LUT_FN_RECIP   = 2'd1,
    LUT_FN_RSQRT   = 2'd2,
    LUT_FN_SIGMOID = 2'd3
  } lut_func_e;

  typedef struct packed {
    logic                     vld;
    logic [LUT_ID_W-1:0]      id;
    logic [LUT_TAG_MAX_W-1:0] tag;
  } lut_pipe_t;

endpackage

// File: rtl/hp_vpu_rr_arbiter.sv
// Round-robin arbiter: request vector to one-hot grant, combinational, zero latency.
// The search starts at an internal pointer that moves past the winner only when advance_i is high.
module hp_vpu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               pos;

  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    ptr_nxt = ptr_q;
    for (int o = 0; o < N; o++) begin
      pos = int'(ptr_q) + o;
      if (pos >= N) pos = pos - N;
      idx = PTR_W'(pos);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = (pos == N - 1) ? '0 : PTR_W'(pos + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/hp_vpu_lut_arbiter.sv
// Shares one LUT ROM port among NREQ requesters; response is valid 1+ROM_LAT cycles after grant.
// One outstanding request per requester; a held response blocks only its own requester.
module hp_vpu_lut_arbiter
  import hp_vpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ROM_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*LUT_IDX_W-1:0]  req_index_i,
  input  logic [NREQ*LUT_FUNC_W-1:0] req_func_i,
  input  logic [NREQ*TAG_W-1:0]      req_tag_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [NREQ*LUT_DATA_W-1:0] rsp_result_o,
  output logic [NREQ*TAG_W-1:0]      rsp_tag_o,
  output logic [LUT_IDX_W-1:0]       rom_index_o,
  output logic [LUT_FUNC_W-1:0]      rom_func_o,
  input  logic [LUT_DATA_W-1:0]      rom_result_i,
  input  logic                       hold_i,
  input  logic                       flush_i,
  output logic                       busy_o
);

  logic [NREQ-1:0]            outstanding_q;
  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            gnt;
  logic [LUT_ID_W-1:0]        gnt_id;
  logic [TAG_W-1:0]           gnt_tag;
  lut_pipe_t                  issue;
  lut_pipe_t                  cap;
  logic [NREQ-1:0]            rsp_vld_q;
  logic [NREQ*LUT_DATA_W-1:0] rsp_res_q;
  logic [NREQ*TAG_W-1:0]      rsp_tag_q;
  logic                       tag_hi_unused;

  // Gating with rst_ni keeps ready and the ROM mux at zero while reset is asserted.
  assign eligible = req_valid_i & ~outstanding_q & {NREQ{~hold_i & ~flush_i & rst_ni}};

  hp_vpu_rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (eligible),
    .advance_i(|gnt),
    .gnt_o    (gnt)
  );

  assign req_ready_o = gnt;

  always_comb begin
    rom_index_o = '0;
    rom_func_o  = '0;
    gnt_id      = '0;
    gnt_tag     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        rom_index_o = req_index_i[i*LUT_IDX_W +: LUT_IDX_W];
        rom_func_o  = req_func_i[i*LUT_FUNC_W +: LUT_FUNC_W];
        gnt_id      = LUT_ID_W'(i);
        gnt_tag     = req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  assign issue = '{vld: |gnt, id: gnt_id, tag: LUT_TAG_MAX_W'(gnt_tag)};

  // The pipe tracks the ROM read latency so the capture stage lines up with rom_result_i.
  if (ROM_LAT == 0) begin : g_comb
    assign cap = issue;
  end else begin : g_pipe
    lut_pipe_t pipe_q [ROM_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < ROM_LAT; k++) pipe_q[k] <= '0;
      end else if (flush_i) begin
        for (int k = 0; k < ROM_LAT; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= issue;
        for (int k = 1; k < ROM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign cap = pipe_q[ROM_LAT-1];
  end

  assign tag_hi_unused = ^(cap.tag >> TAG_W);

  // Capture and handshake never target the same slot: a slot with a pending response has no request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
      rsp_tag_q <= '0;
    end else if (flush_i) begin
      rsp_vld_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap.vld && (cap.id == LUT_ID_W'(i))) begin
          rsp_vld_q[i]                          <= 1'b1;
          rsp_res_q[i*LUT_DATA_W +: LUT_DATA_W] <= rom_result_i;
          rsp_tag_q[i*TAG_W +: TAG_W]           <= cap.tag[TAG_W-1:0];
        end else if (rsp_ready_i[i]) begin
          rsp_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (flush_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= (outstanding_q | gnt) & ~(rsp_vld_q & rsp_ready_i);
    end
  end

  assign rsp_valid_o  = rsp_vld_q;
  assign rsp_result_o = rsp_res_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign busy_o       = |outstanding_q;

endmodule
